cnn_win_fetch_rd: RTL and testbench
===================================

// Module: cnn_win_fetch_rd
// PURPOSE
//  Read-side initiator of the mem_intf_read protocol: fetches one Y_ROWS x Y_COLS
//  window of 8-bit pixels, one request per window row, and packs it into a window buffer.
//  Sits between the CNN control FSM (start/done) and the picture memory responder.
//  Replaces per-row request logic inside cnn; one request outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH     19   byte address width of mem_start_addr
//  BYTES_IN_LINE  32   bytes per mem_data beat (mem_data = BYTES_IN_LINE*8 bits)
//  X_COLS_NUM     28   max picture columns (sizes row_stride)
//  Y_ROWS_NUM      5   max window rows
//  Y_COLS_NUM      5   max window cols (<= BYTES_IN_LINE)
// PORTS
//  clk             in   1                     core clock
//  rst             in   1                     async reset, active-high
//  start           in   1                     1-cycle pulse: fetch one window
//  base_addr       in   ADDR_WIDTH            byte address of window pixel (0,0)
//  row_stride      in   clog2(X_COLS_NUM)+1   bytes between window rows (sw_cnn_x_n)
//  win_rows        in   clog2(Y_ROWS_NUM)+1   active rows, 1..Y_ROWS_NUM
//  win_cols        in   clog2(Y_COLS_NUM)+1   active cols, 1..Y_COLS_NUM
//  mem_req         out  1                     read request
//  mem_start_addr  out  ADDR_WIDTH            request byte address
//  mem_size_bytes  out  clog2(BYTES_IN_LINE)+1  request length = win_cols
//  mem_valid       in   1                     responder grant/data valid
//  last            in   1                     last beat of response
//  mem_data        in   BYTES_IN_LINE*8       byte k at bits [8k+7:8k]
//  mem_last_valid  in   clog2(BYTES_IN_LINE)  index of last valid byte
//  busy            out  1                     fetch in progress
//  win_data        out  Y_ROWS_NUM*Y_COLS_NUM*8  window, row-major, (r,c) at byte r*Y_COLS_NUM+c
//  win_valid       out  1                     1-cycle pulse, win_data complete
//  err             out  1                     sticky protocol error
// BEHAVIOUR
//  - Reset: FSM=IDLE; mem_req=0, mem_start_addr=0, mem_size_bytes=0, busy=0,
//    win_valid=0, err=0, win_data=0, row counter=0.
//  - start sampled only in IDLE: latch base_addr/row_stride/win_rows/win_cols; ignored while busy.
//  - States: IDLE -start-> REQ; REQ -mem_valid-> GAP (row<win_rows-1) | DONE (last row);
//    GAP -> REQ (row+1); DONE -> IDLE.
//  - REQ: mem_req=1, mem_start_addr=base+row*row_stride (mod 2^ADDR_WIDTH),
//    mem_size_bytes=win_cols; held stable until mem_valid=1 (any wait length).
//  - Capture on clk edge with REQ && mem_valid: bytes 0..win_cols-1 -> win_data row;
//    cols >= win_cols and rows >= win_rows forced to 0 for this window.
//  - mem_req drops the cycle after mem_valid (GAP); min 2 cycles/row; min latency
//    start -> win_valid = 2*win_rows cycles.
//  - DONE: win_valid=1 one cycle; win_data holds until next capture; busy=0 in IDLE only.
//  - err set (sticky until rst) on capture if last=0 or mem_last_valid != win_cols-1;
//    data still captured, FSM proceeds.
//  - mem_valid outside REQ ignored (no capture, no err).
//  - start coincident with DONE: ignored (not in IDLE).
//  - rst mid-fetch: immediate return to reset values; partial window discarded.
//  - win_rows/win_cols = 0 or > max: treated as max (clamped at latch).
// STRUCTURE
//  - cnn_mem_pkg: BYTES_IN_LINE, width localparams, typedef enum {IDLE,REQ,GAP,DONE}
//    fetch_state_t, typedef logic [7:0] pix_t.
//  - Sub-module win_row_addr_gen: accumulates row address (base, +stride per GAP);
//    no multiplier.
//  - Top: FSM, row counter, capture mux into win_data register array.
// TESTING
//  - base=0, stride=28, 5x5, responder grants same cycle as req -> addrs 0,28,56,84,112;
//    win_valid 10 cycles after start; win_data == a_data window.
//  - Responder delays grant 3 cycles on row 2 -> mem_req/mem_start_addr=56 stable
//    across wait; win_valid at cycle 13.
//  - 3x3 window, mem_data all 0xFF -> rows 0..2 cols 0..2 = 0xFF, rest 0; size_bytes=3.
//  - mem_last_valid=2 on 5-col fetch -> err=1 sticky, win_valid still pulses.
//  - start again while busy -> ignored, single win_valid; rst asserted mid row 3 ->
//    mem_req=0, busy=0 next cycle, no win_valid.
//  - base=2^19-14, stride=28 -> row 1 address wraps to 14.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// Shared types, widths and helpers for the window-fetch read initiator.
package cnn_mem_pkg;

  localparam int ADDR_WIDTH    = 19;
  localparam int BYTES_IN_LINE = 32;
  localparam int X_COLS_NUM    = 28;
  localparam int Y_ROWS_NUM    = 5;
  localparam int Y_COLS_NUM    = 5;

  localparam int DATA_W   = BYTES_IN_LINE * 8;
  localparam int STRIDE_W = $clog2(X_COLS_NUM) + 1;
  localparam int ROWS_W   = $clog2(Y_ROWS_NUM) + 1;
  localparam int COLS_W   = $clog2(Y_COLS_NUM) + 1;
  localparam int SIZE_W   = $clog2(BYTES_IN_LINE) + 1;
  localparam int LASTV_W  = $clog2(BYTES_IN_LINE);
  localparam int WIN_W    = Y_ROWS_NUM * Y_COLS_NUM * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  typedef logic [7:0] pix_t;

  // Zero or oversized window dimensions fall back to the maximum.
  function automatic logic [ROWS_W-1:0] clamp_dim(input logic [ROWS_W-1:0] v,
                                                  input logic [ROWS_W-1:0] max_v);
    logic [ROWS_W-1:0] res;
    if ((v == '0) || (v > max_v)) begin
      res = max_v;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Byte k of a memory beat.
  function automatic pix_t beat_byte(input logic [DATA_W-1:0] beat, input int k);
    return beat[k*8 +: 8];
  endfunction

endpackage

// File: rtl/cnn_win_fetch_rd_if.sv
// Read-side bus between the window fetcher (master) and picture memory (slave).
interface cnn_win_fetch_rd_if;
  import cnn_mem_pkg::*;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_start_addr;
  logic [SIZE_W-1:0]     mem_size_bytes;
  logic                  mem_valid;
  logic                  last;
  logic [DATA_W-1:0]     mem_data;
  logic [LASTV_W-1:0]    mem_last_valid;

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes,
    input  mem_valid, last, mem_data, mem_last_valid
  );

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes,
    output mem_valid, last, mem_data, mem_last_valid
  );

endinterface

// File: rtl/cnn_win_fetch_rd_addr_gen.sv
// Row address accumulator: loads the window base, then adds the row stride
// once per row step. Wraps naturally modulo 2^ADDR_WIDTH.
module win_row_addr_gen
  import cnn_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [STRIDE_W-1:0]   stride,
  output logic [ADDR_WIDTH-1:0] row_addr
);

  logic [ADDR_WIDTH-1:0] addr_r;

  // Load base on a new window, advance by one stride per row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= '0;
    end else if (load) begin
      addr_r <= base_addr;
    end else if (step) begin
      addr_r <= addr_r + ADDR_WIDTH'(stride);
    end
  end

  assign row_addr = addr_r;

endmodule

// File: rtl/cnn_win_fetch_rd.sv
// Window fetcher: issues one read per window row, packs returned bytes into a
// row-major window buffer and pulses win_valid once the window is complete.
module cnn_win_fetch_rd
  import cnn_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [STRIDE_W-1:0]   row_stride,
  input  logic [ROWS_W-1:0]     win_rows,
  input  logic [COLS_W-1:0]     win_cols,
  cnn_win_fetch_rd_if.master    mem,
  output logic                  busy,
  output logic [WIN_W-1:0]      win_data,
  output logic                  win_valid,
  output logic                  err
);

  fetch_state_t          state_r, next_state_s;
  logic [ROWS_W-1:0]     row_r, rows_r, rows_clamp_s;
  logic [COLS_W-1:0]     cols_r, cols_clamp_s;
  logic [STRIDE_W-1:0]   stride_r;
  logic [SIZE_W-1:0]     size_r;
  logic                  mem_req_r, busy_r, win_valid_r, err_r;
  logic [WIN_W-1:0]      win_r;
  logic [ADDR_WIDTH-1:0] row_addr_s;
  logic                  start_s, capture_s, step_s, last_row_s, bad_beat_s;

  assign rows_clamp_s = clamp_dim(win_rows, ROWS_W'(Y_ROWS_NUM));
  assign cols_clamp_s = COLS_W'(clamp_dim(ROWS_W'(win_cols), ROWS_W'(Y_COLS_NUM)));
  assign start_s      = (state_r == IDLE) && start;
  assign capture_s    = (state_r == REQ) && mem.mem_valid;
  assign step_s       = (state_r == GAP);
  assign last_row_s   = (row_r == (rows_r - ROWS_W'(1)));
  // A beat is malformed if it is not flagged last or its length disagrees with the request.
  assign bad_beat_s   = !mem.last ||
                        (mem.mem_last_valid != (LASTV_W'(cols_r) - LASTV_W'(1)));

  win_row_addr_gen u_addr (
    .clk       (clk),
    .rst       (rst),
    .load      (start_s),
    .step      (step_s),
    .base_addr (base_addr),
    .stride    (stride_r),
    .row_addr  (row_addr_s)
  );

  // Next-state logic: one outstanding request, a gap cycle between rows.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = REQ;
        else       next_state_s = IDLE;
      end
      REQ: begin
        if (mem.mem_valid) begin
          if (last_row_s) next_state_s = DONE;
          else            next_state_s = GAP;
        end else begin
          next_state_s = REQ;
        end
      end
      GAP:     next_state_s = REQ;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register, registered status outputs, window parameters and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      busy_r      <= 1'b0;
      win_valid_r <= 1'b0;
      err_r       <= 1'b0;
      row_r       <= '0;
      rows_r      <= '0;
      cols_r      <= '0;
      stride_r    <= '0;
      size_r      <= '0;
    end else begin
      state_r     <= next_state_s;
      mem_req_r   <= (next_state_s == REQ);
      busy_r      <= (next_state_s != IDLE);
      win_valid_r <= (next_state_s == DONE);
      if (start_s) begin
        rows_r   <= rows_clamp_s;
        cols_r   <= cols_clamp_s;
        stride_r <= row_stride;
        size_r   <= SIZE_W'(cols_clamp_s);
        row_r    <= '0;
      end else if (step_s) begin
        row_r <= row_r + ROWS_W'(1);
      end
      if (capture_s && bad_beat_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Capture the granted beat into the current row; the first row of a window
  // also clears every other row so unused rows read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_r <= '0;
    end else if (capture_s) begin
      for (int r = 0; r < Y_ROWS_NUM; r++) begin
        for (int c = 0; c < Y_COLS_NUM; c++) begin
          if (ROWS_W'(r) == row_r) begin
            win_r[(r*Y_COLS_NUM + c)*8 +: 8] <=
              (COLS_W'(c) < cols_r) ? beat_byte(mem.mem_data, c) : pix_t'(8'h00);
          end else if (row_r == '0) begin
            win_r[(r*Y_COLS_NUM + c)*8 +: 8] <= pix_t'(8'h00);
          end
        end
      end
    end
  end

  assign mem.mem_req        = mem_req_r;
  assign mem.mem_start_addr = row_addr_s;
  assign mem.mem_size_bytes = size_r;
  assign busy               = busy_r;
  assign win_valid          = win_valid_r;
  assign err                = err_r;
  assign win_data           = win_r;

endmodule

// File: tb/tb_cnn_win_fetch_rd.sv
// Self-checking bench for cnn_win_fetch_rd: a behavioural responder serves
// each row request, and expectations come from plain window arithmetic.
module tb_cnn_win_fetch_rd;

  logic         clk;
  logic         rst;
  logic         start;
  logic [18:0]  base_addr;
  logic [5:0]   row_stride;
  logic [3:0]   win_rows;
  logic [3:0]   win_cols;
  logic         busy;
  logic [199:0] win_data;
  logic         win_valid;
  logic         err;

  cnn_win_fetch_rd_if bus ();

  cnn_win_fetch_rd dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .win_rows   (win_rows),
    .win_cols   (win_cols),
    .mem        (bus.master),
    .busy       (busy),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations from the most recent fetch.
  logic [255:0] rowdat [5];
  int           addr_q [$];
  int           size_first;
  int           unstable;
  int           wv_cnt;
  int           wv_cyc;
  logic [199:0] wv_data;
  logic         req_at  [64];
  logic         busy_at [64];
  logic         err_end;

  function automatic int eff(input int v);
    return (v == 0 || v > 5) ? 5 : v;
  endfunction

  // Expected window: pixel (r,c) is byte c of row r's beat inside the active area, else 0.
  function automatic logic [199:0] exp_win(input int nr, input int nc);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r < nr && c < nc) w[(r*5 + c)*8 +: 8] = rowdat[r][c*8 +: 8];
    return w;
  endfunction

  // Runs one window fetch with the bench acting as memory responder.
  // drow/dn: extra grant wait on one row; bmode 1 = wrong last index, 2 = last low;
  // noise: junk valid beats while no request is open; s2/rc: cycle of a
  // second start pulse / of a reset pulse (0 = none); ff: all-0xFF data.
  task automatic do_fetch(input int b, input int s, input int nr, input int nc,
                          input int drow, input int dn, input int bmode, input int noise,
                          input int s2, input int rc, input int ff);
    int cyc, w, g, need, nce;
    logic prev_req;
    logic [18:0] prev_addr;
    nce = eff(nc);
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 8; k++)
        rowdat[r][k*32 +: 32] = ff ? 32'hFFFF_FFFF : $urandom;
    addr_q.delete();
    size_first = -1; unstable = 0; wv_cnt = 0; wv_cyc = -1; wv_data = '0;
    for (int i = 0; i < 64; i++) begin req_at[i] = 1'b0; busy_at[i] = 1'b0; end
    @(negedge clk);
    start = 1'b1; base_addr = 19'(b); row_stride = 6'(s);
    win_rows = 4'(nr); win_cols = 4'(nc);
    cyc = 0; w = 0; g = 0; prev_req = 1'b0; prev_addr = '0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (s2 == cyc) begin start = 1'b1; base_addr = 19'(b + 100); end
      req_at[cyc] = bus.mem_req; busy_at[cyc] = busy;
      if (bus.mem_req && !prev_req) begin
        addr_q.push_back(int'(bus.mem_start_addr));
        size_first = int'(bus.mem_size_bytes);
      end else if (bus.mem_req && prev_req && bus.mem_start_addr != prev_addr) begin
        unstable++;
      end
      prev_req = bus.mem_req; prev_addr = bus.mem_start_addr;
      if (win_valid) begin
        wv_cnt++;
        if (wv_cnt == 1) begin wv_cyc = cyc; wv_data = win_data; end
      end
      rst = (rc == cyc);
      bus.mem_valid = 1'b0; bus.last = 1'b0; bus.mem_data = '0; bus.mem_last_valid = '0;
      if (bus.mem_req && !rst) begin
        need = (g == drow) ? dn : 0;
        if (w >= need) begin
          bus.mem_valid      = 1'b1;
          bus.mem_data       = rowdat[g % 5];
          bus.last           = (bmode != 2);
          bus.mem_last_valid = (bmode == 1) ? 5'd2 : 5'(nce - 1);
          g++; w = 0;
        end else begin
          w++;
        end
      end else if (!bus.mem_req && noise != 0 && ($urandom % 2) == 1) begin
        bus.mem_valid = 1'b1;
        for (int k = 0; k < 8; k++) bus.mem_data[k*32 +: 32] = $urandom;
        bus.last = 1'b0; bus.mem_last_valid = 5'd31;
      end
    end
    rst = 1'b0; start = 1'b0;
    bus.mem_valid = 1'b0; bus.last = 1'b0; bus.mem_data = '0; bus.mem_last_valid = '0;
    err_end = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; row_stride = '0; win_rows = '0; win_cols = '0;
    bus.mem_valid = 1'b0; bus.last = 1'b0; bus.mem_data = '0; bus.mem_last_valid = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", bus.mem_req); end
    total++; if (bus.mem_start_addr !== 19'd0) begin bad++; $display("FAIL reset_addr got %0h want 0", bus.mem_start_addr); end
    total++; if (bus.mem_size_bytes !== 6'd0) begin bad++; $display("FAIL reset_size got %0d want 0", bus.mem_size_bytes); end
    total++; if ({busy, win_valid, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {busy, win_valid, err}); end
    total++; if (win_data !== 200'd0) begin bad++; $display("FAIL reset_win got %0h want 0", win_data); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_fetch(0, 28, 5, 5, -1, 0, 0, 1, 0, 0, 0);
    total++; if (addr_q.size() != 5) begin bad++; $display("FAIL basic_nreq got %0d want 5", addr_q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= addr_q.size() || addr_q[i] != 28*i) begin
        bad++; $display("FAIL basic_addr%0d got %0d want %0d", i, (i < addr_q.size()) ? addr_q[i] : -1, 28*i);
      end
    end
    total++; if (wv_cyc != 10) begin bad++; $display("FAIL basic_latency got %0d want 10", wv_cyc); end
    total++; if (wv_cnt != 1) begin bad++; $display("FAIL basic_pulses got %0d want 1", wv_cnt); end
    total++; if (wv_data !== exp_win(5, 5)) begin bad++; $display("FAIL basic_win got %0h want %0h", wv_data, exp_win(5, 5)); end
    total++; if (size_first != 5) begin bad++; $display("FAIL basic_size got %0d want 5", size_first); end
    total++; if (busy_at[1] !== 1'b1 || busy_at[10] !== 1'b1 || busy_at[11] !== 1'b0) begin
      bad++; $display("FAIL basic_busy got %b%b%b want 110", busy_at[1], busy_at[10], busy_at[11]); end
    total++; if (req_at[2] !== 1'b0) begin bad++; $display("FAIL basic_gap got %b want 0", req_at[2]); end
    total++; if (win_data !== exp_win(5, 5)) begin bad++; $display("FAIL basic_hold got %0h want %0h", win_data, exp_win(5, 5)); end
    total++; if (err_end !== 1'b0) begin bad++; $display("FAIL basic_err got %b want 0", err_end); end
  endtask

  task automatic test_wait();
    int held;
    do_fetch(0, 28, 5, 5, 2, 3, 0, 1, 0, 0, 0);
    held = 0;
    for (int c = 5; c <= 8; c++) if (req_at[c] === 1'b1) held++;
    total++; if (held != 4) begin bad++; $display("FAIL wait_req_held got %0d want 4", held); end
    total++; if (unstable != 0) begin bad++; $display("FAIL wait_addr_stable got %0d want 0", unstable); end
    total++; if (addr_q.size() < 3 || addr_q[2] != 56) begin bad++; $display("FAIL wait_addr2 got %0d want 56", (addr_q.size() >= 3) ? addr_q[2] : -1); end
    total++; if (wv_cyc != 13) begin bad++; $display("FAIL wait_latency got %0d want 13", wv_cyc); end
    total++; if (wv_data !== exp_win(5, 5)) begin bad++; $display("FAIL wait_win got %0h want %0h", wv_data, exp_win(5, 5)); end
  endtask

  task automatic test_small();
    do_fetch(40, 28, 3, 3, -1, 0, 0, 1, 0, 0, 1);
    total++; if (size_first != 3) begin bad++; $display("FAIL small_size got %0d want 3", size_first); end
    total++; if (wv_data !== exp_win(3, 3)) begin bad++; $display("FAIL small_win got %0h want %0h", wv_data, exp_win(3, 3)); end
    total++; if (wv_cyc != 6) begin bad++; $display("FAIL small_latency got %0d want 6", wv_cyc); end
    total++; if (err_end !== 1'b0) begin bad++; $display("FAIL small_err got %b want 0", err_end); end
  endtask

  task automatic test_wrap();
    do_fetch(524288 - 14, 28, 2, 5, -1, 0, 0, 1, 0, 0, 0);
    total++; if (addr_q.size() < 2 || addr_q[0] != 524274 || addr_q[1] != 14) begin
      bad++; $display("FAIL wrap_addr got %0d,%0d want 524274,14",
                      (addr_q.size() > 0) ? addr_q[0] : -1, (addr_q.size() > 1) ? addr_q[1] : -1); end
  endtask

  task automatic test_random();
    int b, s, nr, nc, drow, dn, nre, nce, dly;
    for (int t = 0; t < 5; t++) begin
      b = int'($urandom_range(0, 524287)); s = int'($urandom_range(1, 28));
      nr = int'($urandom_range(0, 7)); nc = int'($urandom_range(0, 9));
      drow = int'($urandom_range(0, 4)); dn = int'($urandom_range(0, 3));
      nre = eff(nr); nce = eff(nc); dly = (drow < nre) ? dn : 0;
      do_fetch(b, s, nr, nc, drow, dn, 0, 1, 0, 0, 0);
      total++; if (addr_q.size() != nre) begin bad++; $display("FAIL rand%0d_nreq got %0d want %0d", t, addr_q.size(), nre); end
      for (int i = 0; i < nre; i++) begin
        total++;
        if (i >= addr_q.size() || addr_q[i] != (b + i*s) % 524288) begin
          bad++; $display("FAIL rand%0d_addr%0d got %0d want %0d", t, i, (i < addr_q.size()) ? addr_q[i] : -1, (b + i*s) % 524288);
        end
      end
      total++; if (size_first != nce) begin bad++; $display("FAIL rand%0d_size got %0d want %0d", t, size_first, nce); end
      total++; if (wv_cyc != 2*nre + dly) begin bad++; $display("FAIL rand%0d_latency got %0d want %0d", t, wv_cyc, 2*nre + dly); end
      total++; if (wv_data !== exp_win(nre, nce)) begin bad++; $display("FAIL rand%0d_win got %0h want %0h", t, wv_data, exp_win(nre, nce)); end
      total++; if (err_end !== 1'b0) begin bad++; $display("FAIL rand%0d_err got %b want 0", t, err_end); end
    end
  endtask

  task automatic test_busy_restart();
    do_fetch(200, 10, 5, 4, -1, 0, 0, 1, 3, 0, 0);
    total++; if (wv_cnt != 1) begin bad++; $display("FAIL busy_pulses got %0d want 1", wv_cnt); end
    total++; if (addr_q.size() != 5 || addr_q[4] != 240) begin
      bad++; $display("FAIL busy_addrs got n=%0d last=%0d want n=5 last=240", addr_q.size(), (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : -1); end
    do_fetch(300, 20, 3, 5, -1, 0, 0, 1, 6, 0, 0);
    total++; if (wv_cnt != 1) begin bad++; $display("FAIL done_start_pulses got %0d want 1", wv_cnt); end
    total++; if (req_at[7] !== 1'b0 || busy_at[8] !== 1'b0) begin
      bad++; $display("FAIL done_start_idle got req=%b busy=%b want 0 0", req_at[7], busy_at[8]); end
  endtask

  task automatic test_err();
    do_fetch(0, 28, 5, 5, -1, 0, 1, 1, 0, 0, 0);
    total++; if (err_end !== 1'b1) begin bad++; $display("FAIL err_set got %b want 1", err_end); end
    total++; if (wv_cnt != 1 || wv_data !== exp_win(5, 5)) begin bad++; $display("FAIL err_pulse got %0d want 1", wv_cnt); end
    do_fetch(0, 28, 2, 5, -1, 0, 0, 1, 0, 0, 0);
    total++; if (err_end !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err_end); end
  endtask

  task automatic test_rst_mid();
    do_fetch(0, 28, 5, 5, -1, 0, 0, 0, 0, 7, 0);
    total++; if (req_at[7] !== 1'b1 || req_at[8] !== 1'b0) begin
      bad++; $display("FAIL rst_req got %b%b want 10", req_at[7], req_at[8]); end
    total++; if (busy_at[8] !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy_at[8]); end
    total++; if (wv_cnt != 0) begin bad++; $display("FAIL rst_no_valid got %0d want 0", wv_cnt); end
    total++; if (win_data !== 200'd0 || err_end !== 1'b0) begin
      bad++; $display("FAIL rst_clear got win=%0h err=%b want 0 0", win_data, err_end); end
    do_fetch(0, 28, 1, 5, -1, 0, 2, 1, 0, 0, 0);
    total++; if (err_end !== 1'b1) begin bad++; $display("FAIL err_last_low got %b want 1", err_end); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_small();
    test_wrap();
    test_random();
    test_busy_restart();
    test_err();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
